// File: rtl/mux_sel_rr_arbiter_if.sv
// mux_sel_rr_arbiter_if: request/grant bundle between the select generator
// and its surroundings. The arbiter uses the slave view. The requester and
// consumer side (or a bench) uses the master view.
interface mux_sel_rr_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic       gnt_valid;
    logic [7:0] gnt_onehot;
    logic       timeout;

    modport master (
        output en, req, done,
        input  sel, gnt_valid, gnt_onehot, timeout
    );

    modport slave (
        input  en, req, done,
        output sel, gnt_valid, gnt_onehot, timeout
    );
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// mux_sel_rr_arbiter: round-robin select generator for an 8:1 mux.
// It picks one of 8 requesters by rotating priority starting at ptr.
// It drives a registered 3-bit select and a one-hot grant.
// The grant is held until the consumer signals done or the requester drops its request.
// A grant is never preempted.
// One IDLE bubble always separates consecutive grants.
// Optional feature: define MUX_SEL_ARB_TIMEOUT_EN to force-release a grant
// after HOLD_MAX cycles and pulse timeout for one cycle.
module mux_sel_rr_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_sel_rr_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Reject configurations where the counter cannot reach the hold limit.
    if (HOLD_MAX < 2 || HOLD_MAX > 256 || (2 ** CNT_W) < HOLD_MAX) begin : g_bad_cfg
        $error("mux_sel_rr_arbiter: illegal HOLD_MAX/CNT_W combination");
    end

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] onehot_q, onehot_d;
    logic       gv_q, gv_d;
    logic       timeout_q, timeout_d;

    logic [2:0] pick;
    logic       normal_rel;
    logic       hold_expired;

    // Rotate-priority encode.
    // Search r starting at bit p and wrap modulo 8.
    // The first set bit wins.
    // Callers only use the result when r is non-zero.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic [2:0] win;
        logic       hit;
        win = p;
        hit = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = p + 3'(k);
            if (!hit && r[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
        return win;
    endfunction

    assign pick       = rr_pick(bus.req, ptr_q);
    // A grant ends when the consumer is done or the owner withdraws its request.
    assign normal_rel = bus.done || !bus.req[sel_q];

`ifdef MUX_SEL_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q;

    assign hold_expired = (state_q == GRANT) && (hold_cnt_q >= CNT_W'(HOLD_MAX - 1));

    // Hold counter: zeroed when a grant is issued, counts GRANT cycles, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else if (state_q == IDLE && state_d == GRANT) begin
            hold_cnt_q <= '0;
        end else if (state_q == GRANT && hold_cnt_q != {CNT_W{1'b1}}) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    // Next-state and next-output logic.
    // Everything defaults to holding its current value.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        onehot_d  = onehot_q;
        gv_d      = gv_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en && (|bus.req)) begin
                    state_d  = GRANT;
                    sel_d    = pick;
                    onehot_d = 8'b1 << pick;
                    gv_d     = 1'b1;
                end
            end
            GRANT: begin
                // A normal release takes precedence over a forced one.
                // In that case timeout stays low.
                if (normal_rel || hold_expired) begin
                    state_d   = IDLE;
                    gv_d      = 1'b0;
                    onehot_d  = 8'h00;
                    ptr_d     = sel_q + 3'd1;
                    timeout_d = hold_expired && !normal_rel;
                end
            end
            default: begin
                state_d  = IDLE;
                gv_d     = 1'b0;
                onehot_d = 8'h00;
            end
        endcase
    end

    // State and registered outputs.
    // Reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            sel_q     <= 3'd0;
            onehot_q  <= 8'h00;
            gv_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            onehot_q  <= onehot_d;
            gv_q      <= gv_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.gnt_valid  = gv_q;
    assign bus.gnt_onehot = onehot_q;
    assign bus.timeout    = timeout_q;

endmodule
